// File: rtl/ai_core_arbiter.sv
// ----------------------------------------------------------------------------
// ai_core_arbiter
//
// Shares a single AI decision core between the two player-side encoders.
// Start pulses from each encoder are latched as pending requests, granted
// round-robin, launched on the core with the owner's player index, and the
// core's result (or DEFAULT_ACTION on timeout) is returned to the owner.
//
// Optional build macro: AI_ARB_STATS_EN
//   defined   -> per-player 8-bit saturating timeout counters
//   undefined -> o_timeout_cnt_p0/p1 tied to zero
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_req_p0/p1         start pulses from the player-0/1 encoders
//   i_abort             game-over/restart, flushes pending work
//   i_core_done         one-cycle result strobe from the core
//   i_core_action[3:0]  core result, valid with i_core_done
//   o_core_start        one-cycle launch pulse to the core
//   o_core_player       player index of the current job
//   o_busy              arbiter is not idle
//   o_action_valid_p0/1 one-cycle result strobe per player
//   o_action[3:0]       result code, holds last value between strobes
//   o_timeout           result came from the timeout path
//   o_timeout_cnt_p0/1  timeout statistics (see macro above)
// ----------------------------------------------------------------------------
module ai_core_arbiter #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000,
  parameter logic [3:0]  DEFAULT_ACTION = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_req_p0,
  input  logic       i_req_p1,
  input  logic       i_abort,
  input  logic       i_core_done,
  input  logic [3:0] i_core_action,
  output logic       o_core_start,
  output logic       o_core_player,
  output logic       o_busy,
  output logic       o_action_valid_p0,
  output logic       o_action_valid_p1,
  output logic [3:0] o_action,
  output logic       o_timeout,
  output logic [7:0] o_timeout_cnt_p0,
  output logic [7:0] o_timeout_cnt_p1
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_LAUNCH = 2'd1;
  localparam logic [1:0]  ST_WAIT   = 2'd2;
  localparam logic [1:0]  ST_RESP   = 2'd3;
  localparam logic [23:0] TIMER_MAX = 24'hFF_FFFF;

  // Round-robin pick: a lone requester wins, a tie goes to the player
  // that was not granted last time.
  function automatic logic pick_grant(input logic p0, input logic p1,
                                      input logic last);
    logic g;
    if (p0 && p1) begin
      g = ~last;
    end else if (p1) begin
      g = 1'b1;
    end else begin
      g = 1'b0;
    end
    return g;
  endfunction

  logic [1:0]  state_r;
  logic [1:0]  state_next_s;
  logic        pend_p0_r;
  logic        pend_p1_r;
  logic        last_grant_r;
  logic [23:0] timer_r;
  logic [3:0]  job_action_r;
  logic        job_timeout_r;
  logic        core_player_r;
  logic        core_start_r;
  logic        busy_r;
  logic        valid_p0_r;
  logic        valid_p1_r;
  logic [3:0]  action_r;
  logic        timeout_r;

  logic        grant_s;
  logic        enter_launch_s;
  logic        timeout_hit_s;
  logic        resp_s;

  assign grant_s        = pick_grant(pend_p0_r, pend_p1_r, last_grant_r);
  assign enter_launch_s = (state_r == ST_IDLE) && (pend_p0_r || pend_p1_r) && !i_abort;
  assign timeout_hit_s  = (timer_r == (TIMEOUT_CYCLES - 24'd1));
  // An abort landing on the RESP cycle swallows that job's strobe.
  assign resp_s         = (state_r == ST_RESP) && !i_abort;

  // Next-state decode; abort overrides every state.
  always_comb begin
    state_next_s = state_r;
    if (i_abort) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pend_p0_r || pend_p1_r) begin
            state_next_s = ST_LAUNCH;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_LAUNCH: state_next_s = ST_WAIT;
        ST_WAIT: begin
          if (i_core_done || timeout_hit_s) begin
            state_next_s = ST_RESP;
          end else begin
            state_next_s = ST_WAIT;
          end
        end
        ST_RESP: state_next_s = ST_IDLE;
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Pending request latches: a new pulse beats the clear from being granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_p0_r <= 1'b0;
      pend_p1_r <= 1'b0;
    end else if (i_abort) begin
      pend_p0_r <= 1'b0;
      pend_p1_r <= 1'b0;
    end else begin
      pend_p0_r <= i_req_p0 | (pend_p0_r & ~(enter_launch_s & ~grant_s));
      pend_p1_r <= i_req_p1 | (pend_p1_r & ~(enter_launch_s &  grant_s));
    end
  end

  // Grant bookkeeping; survives abort so fairness carries across games.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r  <= 1'b1;
      core_player_r <= 1'b0;
    end else if (enter_launch_s) begin
      last_grant_r  <= grant_s;
      core_player_r <= grant_s;
    end else begin
      last_grant_r  <= last_grant_r;
      core_player_r <= core_player_r;
    end
  end

  // WAIT-cycle timer; cleared at launch, saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_r <= 24'd0;
    end else if (i_abort || (state_r == ST_LAUNCH)) begin
      timer_r <= 24'd0;
    end else if ((state_r == ST_WAIT) && (timer_r != TIMER_MAX)) begin
      timer_r <= timer_r + 24'd1;
    end else begin
      timer_r <= timer_r;
    end
  end

  // Capture the job result; a core result wins over a coincident timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_action_r  <= 4'd0;
      job_timeout_r <= 1'b0;
    end else if ((state_r == ST_WAIT) && !i_abort && i_core_done) begin
      job_action_r  <= i_core_action;
      job_timeout_r <= 1'b0;
    end else if ((state_r == ST_WAIT) && !i_abort && timeout_hit_s) begin
      job_action_r  <= DEFAULT_ACTION;
      job_timeout_r <= 1'b1;
    end else begin
      job_action_r  <= job_action_r;
      job_timeout_r <= job_timeout_r;
    end
  end

  // Registered outputs decoded from the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_start_r <= 1'b0;
      busy_r       <= 1'b0;
      valid_p0_r   <= 1'b0;
      valid_p1_r   <= 1'b0;
      action_r     <= 4'd0;
      timeout_r    <= 1'b0;
    end else begin
      core_start_r <= (state_r == ST_LAUNCH) && !i_abort;
      busy_r       <= (state_r != ST_IDLE) && !i_abort;
      valid_p0_r   <= resp_s && !core_player_r;
      valid_p1_r   <= resp_s &&  core_player_r;
      action_r     <= resp_s ? job_action_r : action_r;
      timeout_r    <= resp_s && job_timeout_r;
    end
  end

  assign o_core_start      = core_start_r;
  assign o_core_player     = core_player_r;
  assign o_busy            = busy_r;
  assign o_action_valid_p0 = valid_p0_r;
  assign o_action_valid_p1 = valid_p1_r;
  assign o_action          = action_r;
  assign o_timeout         = timeout_r;

`ifdef AI_ARB_STATS_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

  logic [7:0] cnt_p0_r;
  logic [7:0] cnt_p1_r;

  // Timeout statistics, counted as the timeout strobe is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0_r <= 8'd0;
      cnt_p1_r <= 8'd0;
    end else begin
      cnt_p0_r <= (resp_s && job_timeout_r && !core_player_r) ? sat_inc(cnt_p0_r) : cnt_p0_r;
      cnt_p1_r <= (resp_s && job_timeout_r &&  core_player_r) ? sat_inc(cnt_p1_r) : cnt_p1_r;
    end
  end

  assign o_timeout_cnt_p0 = cnt_p0_r;
  assign o_timeout_cnt_p1 = cnt_p1_r;
`else
  assign o_timeout_cnt_p0 = 8'd0;
  assign o_timeout_cnt_p1 = 8'd0;
`endif

endmodule
